// File: rtl/moving_average_param.sv
// Sliding-window averager over a signed sample stream with run-time power-of-two
// window, exact running sum, fill tracking, decimated output and restart on window change.
module moving_average_param #(
  parameter int DATA_W       = 16,
  parameter int LOG2_MAX_WIN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     data_refresh_i,
  input  logic                     output_refresh_mode_i,
  input  logic [2:0]               win_sel_i,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] dout_o,
  output logic                     output_pulse_o,
  output logic                     filled_o
);

  localparam int MAX_WIN = 1 << LOG2_MAX_WIN;
  localparam int SUM_W   = DATA_W + LOG2_MAX_WIN;
  localparam int CNT_W   = LOG2_MAX_WIN + 1;

  logic signed [DATA_W-1:0] buf_mem [MAX_WIN];

  logic [LOG2_MAX_WIN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_MAX_WIN-1:0] dec_q, dec_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic [2:0]              k_q, k_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                    pulse_q, pulse_d;

  logic [2:0]              k_sel;
  logic [CNT_W-1:0]        n_win;
  logic [LOG2_MAX_WIN-1:0] old_idx;
  logic                    full, restart, accept, dec_last;
  logic signed [SUM_W-1:0] din_ext, old_ext, sum_nxt, shifted;

  assign k_sel   = (win_sel_i > 3'(LOG2_MAX_WIN)) ? 3'(LOG2_MAX_WIN) : win_sel_i;
  assign n_win   = CNT_W'(1) << k_q;
  assign full    = (fill_q == n_win);
  // When N == MAX_WIN the low bits of n_win are zero, so the oldest entry is the one about to be overwritten.
  assign old_idx = wr_ptr_q - n_win[LOG2_MAX_WIN-1:0];

  assign restart  = enable_i && (k_sel != k_q);
  assign accept   = enable_i && data_refresh_i && !restart;
  assign dec_last = ({1'b0, dec_q} == (n_win - 1'b1));

  assign din_ext = {{LOG2_MAX_WIN{din_i[DATA_W-1]}}, din_i};
  assign old_ext = full ? {{LOG2_MAX_WIN{buf_mem[old_idx][DATA_W-1]}}, buf_mem[old_idx]}
                        : '0;
  assign sum_nxt = sum_q + din_ext - old_ext;
  assign shifted = sum_nxt >>> k_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    dec_d    = dec_q;
    fill_d   = fill_q;
    k_d      = k_q;
    sum_d    = sum_q;
    dout_d   = dout_q;
    pulse_d  = 1'b0;
    if (restart) begin
      k_d    = k_sel;
      sum_d  = '0;
      fill_d = '0;
      dec_d  = '0;
    end else if (accept) begin
      sum_d    = sum_nxt;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (!full) fill_d = fill_q + 1'b1;
      dec_d    = dec_last ? '0 : dec_q + 1'b1;
      pulse_d  = output_refresh_mode_i || dec_last;
      if (pulse_d) dout_d = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      dec_q    <= '0;
      fill_q   <= '0;
      k_q      <= '0;
      sum_q    <= '0;
      dout_q   <= '0;
      pulse_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      dec_q    <= dec_d;
      fill_q   <= fill_d;
      k_q      <= k_d;
      sum_q    <= sum_d;
      dout_q   <= dout_d;
      pulse_q  <= pulse_d;
    end
  end

  // Buffer is left unreset: entries are only read once the fill count proves they were written.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_ptr_q] <= din_i;
  end

  assign dout_o         = dout_q;
  assign output_pulse_o = pulse_q;
  assign filled_o       = full;

endmodule
